fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch front end that sits directly upstream of the decode/control block. It owns the fetch PC and sequences single-outstanding requests to an instruction memory with variable latency. It holds each returned instruction in an IF/ID output register with valid/stall handshaking and a one-entry skid buffer. Branch/jump redirects from execute flush the register and discard any in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset.
NOP_INSTR, 32'h0000_0013, value driven on o_instr whenever o_valid is low (addi x0,x0,0).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
i_stall  input  1  decode not ready; hold IF/ID contents.
i_redirect  input  1  one-cycle pulse: taken branch/jump, flush and refetch.
i_redirect_pc  input  32  redirect target; bits [1:0] forced to 0 internally.
o_imem_req  output  1  one-cycle request pulse.
o_imem_addr  output  32  fetch address; stable from the req pulse until the response.
i_imem_rdata  input  32  instruction word, qualified by i_imem_valid.
i_imem_valid  input  1  response strobe; at least 1 cycle after the req pulse.
o_valid  output  1  IF/ID holds a valid instruction.
o_instr  output  32  instruction word.
o_pc  output  32  address of o_instr.
o_pc_plus4  output  32  o_pc + 4, modulo 2^32.

Behaviour:
- Reset (rst high at an edge): state=IDLE; fetch_pc=RESET_PC; o_valid=0; o_instr=NOP_INSTR; o_pc=0; o_pc_plus4=4; o_imem_req=0; skid empty; kill=0. Reset overrides all inputs, including mid-request; a response arriving after reset is ignored unless state is WAIT.
- o_imem_addr = fetch_pc at all times.
- FSM states and transitions:
  - IDLE -> REQ. Entered only after reset.
  - REQ: o_imem_req=1 for this cycle only. Next state is WAIT.
  - WAIT: wait for i_imem_valid.
    - On valid with kill=1: drop the response, clear kill, go to REQ.
    - On valid with IF/ID free (o_valid=0 or i_stall=0): load IF/ID with {rdata, fetch_pc}, set o_valid=1, fetch_pc+=4, go to REQ.
    - On valid with IF/ID full and i_stall=1: capture {rdata, fetch_pc} into the skid buffer, fetch_pc+=4, go to HOLD.
  - HOLD: no request is issued. When i_stall=0, move skid into IF/ID (o_valid stays 1), empty skid, go to REQ.
- Downstream consumption: if o_valid=1, i_stall=0 and no new load occurs that cycle, o_valid goes to 0 next cycle and o_instr returns to NOP_INSTR.
- Redirect (i_redirect=1) has priority over stall, valid and HOLD:
  - Next cycle: o_valid=0, skid empty, fetch_pc=i_redirect_pc & ~3.
  - If in WAIT with no i_imem_valid this cycle: set kill=1 and stay in WAIT; the stale response is dropped, then go to REQ.
  - If in WAIT and i_imem_valid is this cycle: drop it and go to REQ.
  - From REQ: the request just issued is outstanding, so set kill=1 and go to WAIT.
  - From HOLD or IDLE: go to REQ.
- Throughput: at most 1 instruction per 2 cycles with a 1-cycle memory. Latency from req pulse to o_valid is the memory latency + 1 cycle.
- fetch_pc wraps 32'hFFFF_FFFC -> 0. No misalignment trap.
- Exactly one outstanding request at any time; o_imem_req never asserts in WAIT or HOLD.

Test Plan:
- Reset release, 1-cycle memory returning addr^32'hA5A5_0000: req pulses at PC 0,4,8; o_valid/o_pc sequence 0,4,8 with matching instrs; o_pc_plus4=4,8,12; o_instr=0x13 while invalid.
- Hold i_stall=1 for 6 cycles after first valid: IF/ID stays {pc 0}, skid captures pc 4, no req issued in HOLD; on release pc 4 appears next cycle, then req at 8.
- Redirect to 32'h0000_0103 while WAIT (3-cycle memory): response for the old PC is dropped, o_valid=0, next req addr=0x100, first valid o_pc=0x100.
- Redirect in the same cycle as i_imem_valid with i_stall=1: the instruction is not loaded, o_valid=0 next cycle, next req to the target.
- Assert rst mid-WAIT then a late i_imem_valid: outputs equal reset values, first req addr=RESET_PC, the late response is not loaded.
- Redirect to 32'hFFFF_FFFC: fetch order 0xFFFFFFFC then 0x00000000; o_pc_plus4 for the first = 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding imem
// request at a time, and feeds decode through an IF/ID register with a one-entry skid.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_valid,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    // state   | meaning
    // IDLE    | just out of reset, nothing in flight
    // REQ     | request pulse on o_imem_req this cycle
    // WAIT    | one request outstanding, waiting for i_imem_valid
    // HOLD    | IF/ID and skid both full, decode stalled
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        kill_q, kill_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        skid_full_q, skid_full_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        ifid_free;
    logic [31:0] fetch_pc_next;
    logic [31:0] redirect_target;

    assign ifid_free       = !valid_q || !i_stall;
    assign fetch_pc_next   = fetch_pc_q + 32'd4;
    assign redirect_target = {i_redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        kill_d       = kill_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        skid_full_d  = skid_full_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        // decode takes the current word; a load below overrides this
        if (valid_q && !i_stall) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_imem_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else if (ifid_free) begin
                        valid_d    = 1'b1;
                        instr_d    = i_imem_rdata;
                        pc_d       = fetch_pc_q;
                        fetch_pc_d = fetch_pc_next;
                        state_d    = ST_REQ;
                    end else begin
                        skid_full_d  = 1'b1;
                        skid_instr_d = i_imem_rdata;
                        skid_pc_d    = fetch_pc_q;
                        fetch_pc_d   = fetch_pc_next;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!i_stall) begin
                    valid_d     = 1'b1;
                    instr_d     = skid_instr_q;
                    pc_d        = skid_pc_q;
                    skid_full_d = 1'b0;
                    state_d     = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A redirect flushes everything; an already-issued request must be
        // remembered as stale so its response gets dropped.
        if (i_redirect) begin
            valid_d     = 1'b0;
            skid_full_d = 1'b0;
            fetch_pc_d  = redirect_target;
            case (state_q)
                ST_WAIT: begin
                    if (i_imem_valid) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
                ST_REQ: begin
                    kill_d  = 1'b1;
                    state_d = ST_WAIT;
                end
                default: begin
                    kill_d  = 1'b0;
                    state_d = ST_REQ;
                end
            endcase
        end

        req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fetch_pc_q   <= RESET_PC;
            kill_q       <= 1'b0;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc_q         <= 32'd0;
            skid_full_q  <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            kill_q       <= kill_d;
            req_q        <= req_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            skid_full_q  <= skid_full_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign o_imem_req  = req_q;
    assign o_imem_addr = fetch_pc_q;
    assign o_valid     = valid_q;
    assign o_instr     = valid_q ? instr_q : NOP_INSTR;
    assign o_pc        = pc_q;
    assign o_pc_plus4  = pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory model plus an instruction-stream
// reference (expected PC sequence) checked at every decode acceptance.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] MAGIC     = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_stall = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'd0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rdata = 32'd0;
    logic        i_imem_valid = 1'b0;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_stall      (i_stall),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_rdata (i_imem_rdata),
        .i_imem_valid (i_imem_valid),
        .o_valid      (o_valid),
        .o_instr      (o_instr),
        .o_pc         (o_pc),
        .o_pc_plus4   (o_pc_plus4)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          n_acc = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic        mem_pend = 1'b0;
    int          mem_cnt = 0;
    int          mem_lat = 1;
    logic [31:0] mem_addr = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // One clock: score any acceptance, advance, then play the memory for the new cycle.
    task automatic tick();
        logic acc;
        acc = (o_valid === 1'b1) && !i_stall && !rst;
        if (acc) begin
            chk("stream_pc", o_pc, exp_pc);
            chk("stream_instr", o_instr, exp_pc ^ MAGIC);
            chk("stream_plus4", o_pc_plus4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            n_acc++;
        end
        if (rst) exp_pc = RESET_PC;
        else if (i_redirect) exp_pc = i_redirect_pc & ~32'd3;
        @(posedge clk);
        #1;
        i_redirect   = 1'b0;
        i_imem_valid = 1'b0;
        i_imem_rdata = $urandom;
        if (mem_pend) begin
            if (mem_cnt <= 1) begin
                i_imem_valid = 1'b1;
                i_imem_rdata = mem_addr ^ MAGIC;
                mem_pend     = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        if (o_imem_req === 1'b1) begin
            chk("one_outstanding", {31'd0, mem_pend}, 32'd0);
            mem_pend = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = o_imem_addr;
        end
        if (o_valid === 1'b0) chk("nop_when_invalid", o_instr, NOP_INSTR);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (o_imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, o_imem_req}, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (o_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, o_valid}, 32'd1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_instr", o_instr, NOP_INSTR);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_plus4", o_pc_plus4, 32'd4);
        chk("rst_req", {31'd0, o_imem_req}, 32'd0);
        chk("rst_addr", o_imem_addr, RESET_PC);
    endtask

    initial begin
        int n_rand;

        // 1-cycle memory, free-running fetch
        mem_lat = 1;
        do_reset();
        chk_reset_outputs();
        tick();
        chk("t1_req0", {31'd0, o_imem_req}, 32'd1);
        chk("t1_addr0", o_imem_addr, 32'd0);
        tick();
        chk("t1_wait_req", {31'd0, o_imem_req}, 32'd0);
        chk("t1_wait_valid", {31'd0, o_valid}, 32'd0);
        tick();
        chk("t1_valid0", {31'd0, o_valid}, 32'd1);
        chk("t1_pc0", o_pc, 32'd0);
        chk("t1_instr0", o_instr, 32'd0 ^ MAGIC);
        chk("t1_plus4_0", o_pc_plus4, 32'd4);
        chk("t1_req4", {31'd0, o_imem_req}, 32'd1);
        chk("t1_addr4", o_imem_addr, 32'd4);
        tick();
        chk("t1_consumed", {31'd0, o_valid}, 32'd0);
        tick();
        chk("t1_pc4", o_pc, 32'd4);
        chk("t1_instr4", o_instr, 32'd4 ^ MAGIC);
        chk("t1_addr8", o_imem_addr, 32'd8);
        tick();
        tick();
        chk("t1_pc8", o_pc, 32'd8);
        chk("t1_plus4_8", o_pc_plus4, 32'd12);

        // stall for 6 cycles right after the first valid
        do_reset();
        tick();
        tick();
        tick();
        chk("t2_valid0", {31'd0, o_valid}, 32'd1);
        i_stall = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("t2_hold_req", {31'd0, o_imem_req}, 32'd0);
            chk("t2_hold_valid", {31'd0, o_valid}, 32'd1);
            chk("t2_hold_pc", o_pc, 32'd0);
        end
        i_stall = 1'b0;
        tick();
        chk("t2_skid_valid", {31'd0, o_valid}, 32'd1);
        chk("t2_skid_pc", o_pc, 32'd4);
        chk("t2_skid_instr", o_instr, 32'd4 ^ MAGIC);
        chk("t2_req8", {31'd0, o_imem_req}, 32'd1);
        chk("t2_addr8", o_imem_addr, 32'd8);

        // redirect while WAIT, 3-cycle memory
        do_reset();
        mem_lat = 3;
        tick();
        tick();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0103;
        tick();
        chk("t3_addr", o_imem_addr, 32'h0000_0100);
        chk("t3_noreq", {31'd0, o_imem_req}, 32'd0);
        wait_req("t3_req_seen");
        chk("t3_dropped", {31'd0, o_valid}, 32'd0);
        chk("t3_req_addr", o_imem_addr, 32'h0000_0100);
        wait_valid("t3_valid_seen");
        chk("t3_pc", o_pc, 32'h0000_0100);
        chk("t3_instr", o_instr, 32'h0000_0100 ^ MAGIC);

        // redirect coincident with the response while stalled and full
        do_reset();
        mem_lat = 1;
        tick();
        tick();
        tick();
        chk("t4_valid0", {31'd0, o_valid}, 32'd1);
        i_stall = 1'b1;
        tick();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0200;
        tick();
        chk("t4_flushed", {31'd0, o_valid}, 32'd0);
        chk("t4_req", {31'd0, o_imem_req}, 32'd1);
        chk("t4_addr", o_imem_addr, 32'h0000_0200);
        i_stall = 1'b0;
        wait_valid("t4_valid_seen");
        chk("t4_pc", o_pc, 32'h0000_0200);

        // reset in the middle of WAIT, response arrives after reset
        mem_lat = 2;
        tick();
        wait_req("t5_req_seen");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_late_strobe", {31'd0, i_imem_valid}, 32'd1);
        chk_reset_outputs();
        tick();
        chk("t5_req", {31'd0, o_imem_req}, 32'd1);
        chk("t5_req_addr", o_imem_addr, RESET_PC);
        chk("t5_not_loaded", {31'd0, o_valid}, 32'd0);
        wait_valid("t5_valid_seen");
        chk("t5_pc", o_pc, RESET_PC);
        chk("t5_instr", o_instr, RESET_PC ^ MAGIC);

        // wrap at the top of the address space
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFC;
        tick();
        wait_req("t6_req_seen");
        chk("t6_req_addr", o_imem_addr, 32'hFFFF_FFFC);
        wait_valid("t6_valid_top");
        chk("t6_pc_top", o_pc, 32'hFFFF_FFFC);
        chk("t6_plus4_top", o_pc_plus4, 32'd0);
        tick();
        wait_valid("t6_valid_zero");
        chk("t6_pc_zero", o_pc, 32'd0);
        chk("t6_plus4_zero", o_pc_plus4, 32'd4);

        // random stall / redirect / latency mix against the stream reference
        n_rand = n_acc;
        for (int i = 0; i < 3000; i++) begin
            mem_lat = int'($urandom_range(1, 4));
            i_stall = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 4) begin
                i_redirect = 1'b1;
                if ($urandom_range(0, 3) == 0) i_redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                else i_redirect_pc = $urandom;
            end
            tick();
        end
        i_stall = 1'b0;
        chk("rand_progress", {31'd0, (n_acc - n_rand) >= 100}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
